// File: rtl/oc8051_cxrom_arb_pkg.sv
// Shared types and default sizing for the oc8051 code-ROM arbiter.
package oc8051_cxrom_pkg;
   localparam int unsigned AW_DEF       = 16;
   localparam int unsigned DW_DEF       = 32;
   localparam int unsigned STEP_DEF     = 4;
   localparam int unsigned MAX_WAIT_DEF = 4;

   typedef enum logic [1:0] {IDLE, SINGLE, BURST} state_t;
   typedef enum logic {SRC_CPU, SRC_HSH} src_t;
endpackage

// File: rtl/oc8051_cxrom_arb_if.sv
// Requester and ROM-side signals of the code-ROM arbiter.
interface oc8051_cxrom_arb_if
   import oc8051_cxrom_pkg::*;
#(
   parameter int unsigned AW = AW_DEF,
   parameter int unsigned DW = DW_DEF
);
   logic          cpu_req;
   logic [AW-1:0] cpu_addr;
   logic          cpu_gnt;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_rvalid;
   logic          hsh_req;
   logic [AW-1:0] hsh_addr;
   logic [3:0]    hsh_len;
   logic          hsh_gnt;
   logic [DW-1:0] hsh_rdata;
   logic          hsh_rvalid;
   logic          hsh_busy;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_data;

   modport slave (
      input  cpu_req, cpu_addr, hsh_req, hsh_addr, hsh_len, rom_data,
      output cpu_gnt, cpu_rdata, cpu_rvalid, hsh_gnt, hsh_rdata, hsh_rvalid,
             hsh_busy, rom_addr
   );

   modport master (
      output cpu_req, cpu_addr, hsh_req, hsh_addr, hsh_len, rom_data,
      input  cpu_gnt, cpu_rdata, cpu_rvalid, hsh_gnt, hsh_rdata, hsh_rvalid,
             hsh_busy, rom_addr
   );
endinterface

// File: rtl/oc8051_cxrom_arb_prio.sv
// Starvation-guarded CPU/HSH priority picker with the HSH wait counter.
module oc8051_cxrom_prio
   import oc8051_cxrom_pkg::*;
#(
   parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic i_window,
   input  logic i_cpu_req,
   input  logic i_hsh_req,
   output logic o_cpu_gnt,
   output logic o_hsh_gnt
);
   localparam logic [3:0] W_MAX = 4'(MAX_WAIT);

   logic [3:0] r_wait_cnt;
   logic       w_starved;

   always_comb begin
      o_cpu_gnt = 1'b0;
      o_hsh_gnt = 1'b0;
      w_starved = i_hsh_req && (r_wait_cnt == W_MAX);
      if (i_window && !rst) begin
         if (w_starved)      o_hsh_gnt = 1'b1;
         else if (i_cpu_req) o_cpu_gnt = 1'b1;
         else if (i_hsh_req) o_hsh_gnt = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                     r_wait_cnt <= '0;
      else if (o_hsh_gnt)                          r_wait_cnt <= '0;
      else if (i_hsh_req && (r_wait_cnt != W_MAX)) r_wait_cnt <= r_wait_cnt + 4'd1;
   end
endmodule

// File: rtl/oc8051_cxrom_arb.sv
// Shares the combinational code ROM between CPU fetch and the hash engine.
module oc8051_cxrom_arb
   import oc8051_cxrom_pkg::*;
#(
   parameter int unsigned AW       = AW_DEF,
   parameter int unsigned DW       = DW_DEF,
   parameter int unsigned MAX_WAIT = MAX_WAIT_DEF,
   parameter int unsigned STEP     = STEP_DEF
) (
   input  logic               clk,
   input  logic               rst,
   oc8051_cxrom_arb_if.slave  bus
);
   state_t        r_state, w_state_nxt;
   src_t          r_src, r_vsrc;
   logic [AW-1:0] r_addr;
   logic [3:0]    r_remain;
   logic [DW-1:0] r_rdata;
   logic          r_valid, r_busy;
   logic          w_window, w_capture, w_cpu_gnt, w_hsh_gnt;

   oc8051_cxrom_prio #(.MAX_WAIT(MAX_WAIT)) u_prio (
      .clk       (clk),
      .rst       (rst),
      .i_window  (w_window),
      .i_cpu_req (bus.cpu_req),
      .i_hsh_req (bus.hsh_req),
      .o_cpu_gnt (w_cpu_gnt),
      .o_hsh_gnt (w_hsh_gnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // BURST only while beats remain; the last beat is issued from SINGLE,
   // which is what opens the grant window on the final-address cycle.
   always_comb begin
      w_state_nxt = IDLE;
      if (w_cpu_gnt)              w_state_nxt = SINGLE;
      else if (w_hsh_gnt)         w_state_nxt = (bus.hsh_len != 4'd0) ? BURST : SINGLE;
      else if (r_state == BURST)  w_state_nxt = (r_remain == 4'd1) ? SINGLE : BURST;
   end

   always_comb begin
      w_window       = (r_state != BURST);
      w_capture      = (r_state != IDLE);
      bus.cpu_gnt    = w_cpu_gnt;
      bus.hsh_gnt    = w_hsh_gnt;
      bus.rom_addr   = r_addr;
      bus.cpu_rdata  = r_rdata;
      bus.hsh_rdata  = r_rdata;
      bus.cpu_rvalid = r_valid && (r_vsrc == SRC_CPU);
      bus.hsh_rvalid = r_valid && (r_vsrc == SRC_HSH);
      bus.hsh_busy   = r_busy;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr   <= '0;
         r_remain <= '0;
         r_src    <= SRC_CPU;
         r_vsrc   <= SRC_CPU;
         r_rdata  <= '0;
         r_valid  <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         if (w_cpu_gnt) begin
            r_addr   <= bus.cpu_addr;
            r_remain <= '0;
            r_src    <= SRC_CPU;
         end else if (w_hsh_gnt) begin
            r_addr   <= bus.hsh_addr;
            r_remain <= bus.hsh_len;
            r_src    <= SRC_HSH;
         end else if (r_state == BURST) begin
            r_addr   <= r_addr + AW'(STEP);
            r_remain <= r_remain - 4'd1;
         end
         r_valid <= w_capture;
         if (w_capture) begin
            r_rdata <= bus.rom_data;
            r_vsrc  <= r_src;
         end
         r_busy <= w_hsh_gnt || (r_state == BURST);
      end
   end
endmodule

// File: tb/tb_oc8051_cxrom_arb.sv
// Directed self-checking bench for oc8051_cxrom_arb with a hashed ROM model.
module tb_oc8051_cxrom_arb;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tot = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   oc8051_cxrom_arb_if #(.AW(16), .DW(32)) bus ();

   oc8051_cxrom_arb #(.AW(16), .DW(32), .MAX_WAIT(4), .STEP(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [31:0] rom_f(input logic [15:0] a);
      return {a ^ 16'hA5A5, a + 16'h1234};
   endfunction

   assign bus.rom_data = rom_f(bus.rom_addr);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic cpu_read(input logic [15:0] a);
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = a;
      #1;
      chk("cpu_gnt", bus.cpu_gnt, 1);
      chk("cpu_hgnt", bus.hsh_gnt, 0);
      step();
      bus.cpu_req = 1'b0;
      chk("cpu_rom_addr", bus.rom_addr, a);
      chk("cpu_rvalid_t1", bus.cpu_rvalid, 0);
      step();
      chk("cpu_rvalid_t2", bus.cpu_rvalid, 1);
      chk("cpu_rdata", bus.cpu_rdata, rom_f(a));
      chk("cpu_hrvalid_t2", bus.hsh_rvalid, 0);
      step();
      chk("cpu_rvalid_t3", bus.cpu_rvalid, 0);
   endtask

   task automatic hsh_burst_start(input logic [15:0] a, input logic [3:0] len);
      bus.hsh_req  = 1'b1;
      bus.hsh_addr = a;
      bus.hsh_len  = len;
      #1;
      chk("hsh_gnt", bus.hsh_gnt, 1);
      step();
      bus.hsh_req = 1'b0;
   endtask

   initial begin
      logic [15:0] ea;
      logic [15:0] wrap_addrs [4];
      wrap_addrs = '{16'hFFF8, 16'hFFFC, 16'h0000, 16'h0004};
      bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0010;
      bus.hsh_req = 1'b1; bus.hsh_addr = 16'h0100; bus.hsh_len = 4'd0;

      // reset state, grants suppressed while rst
      #3;
      chk("rst_cpu_gnt", bus.cpu_gnt, 0);
      chk("rst_hsh_gnt", bus.hsh_gnt, 0);
      chk("rst_rom_addr", bus.rom_addr, 0);
      chk("rst_rdata", bus.cpu_rdata, 0);
      chk("rst_rvalid", {bus.cpu_rvalid, bus.hsh_rvalid}, 0);
      chk("rst_busy", bus.hsh_busy, 0);
      bus.cpu_req = 1'b0; bus.hsh_req = 1'b0;
      step();
      rst = 1'b0;

      // single CPU read
      cpu_read(16'h0010);

      // 4-beat HSH burst
      hsh_burst_start(16'h0100, 4'd3);
      for (int i = 0; i < 4; i++) begin
         ea = 16'h0100 + 16'(4 * i);
         chk("b4_addr", bus.rom_addr, ea);
         chk("b4_busy", bus.hsh_busy, 1);
         chk("b4_cpu_rvalid", bus.cpu_rvalid, 0);
         if (i > 0) begin
            chk("b4_rvalid", bus.hsh_rvalid, 1);
            chk("b4_rdata", bus.hsh_rdata, rom_f(ea - 16'd4));
         end
         step();
      end
      chk("b4_busy_end", bus.hsh_busy, 0);
      chk("b4_rvalid_last", bus.hsh_rvalid, 1);
      chk("b4_rdata_last", bus.hsh_rdata, rom_f(16'h010C));
      step();
      chk("b4_rvalid_off", bus.hsh_rvalid, 0);

      // starvation guard: four CPU grants then HSH
      do_reset();
      bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0300;
      bus.hsh_req = 1'b1; bus.hsh_addr = 16'h0200; bus.hsh_len = 4'd0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("starve_cpu_gnt", bus.cpu_gnt, (k < 4) ? 1 : 0);
         chk("starve_hsh_gnt", bus.hsh_gnt, (k == 4) ? 1 : 0);
         step();
      end
      chk("starve_rom_addr", bus.rom_addr, 16'h0200);
      chk("starve_busy", bus.hsh_busy, 1);
      #1;
      chk("wait_clr_cpu_gnt", bus.cpu_gnt, 1);
      chk("wait_clr_hsh_gnt", bus.hsh_gnt, 0);
      step();
      bus.cpu_req = 1'b0; bus.hsh_req = 1'b0;
      chk("starve_rom_addr2", bus.rom_addr, 16'h0300);
      chk("starve_hrvalid", bus.hsh_rvalid, 1);
      chk("starve_hrdata", bus.hsh_rdata, rom_f(16'h0200));
      chk("starve_busy_off", bus.hsh_busy, 0);
      step();
      chk("starve_crvalid", bus.cpu_rvalid, 1);
      chk("starve_crdata", bus.cpu_rdata, rom_f(16'h0300));
      chk("starve_hrvalid_off", bus.hsh_rvalid, 0);
      step();

      // address wrap
      hsh_burst_start(16'hFFF8, 4'd3);
      for (int i = 0; i < 4; i++) begin
         chk("wrap_addr", bus.rom_addr, wrap_addrs[i]);
         step();
      end
      chk("wrap_rdata_last", bus.hsh_rdata, rom_f(16'h0004));
      step();

      // CPU waits through a 16-beat burst, then follows with no bubble
      hsh_burst_start(16'h0400, 4'd15);
      bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0500;
      for (int j = 1; j <= 16; j++) begin
         #1;
         chk("b16_cpu_gnt", bus.cpu_gnt, (j == 16) ? 1 : 0);
         chk("b16_addr", bus.rom_addr, 16'h0400 + 16'(4 * (j - 1)));
         chk("b16_busy", bus.hsh_busy, 1);
         step();
      end
      bus.cpu_req = 1'b0;
      chk("b16_cpu_addr", bus.rom_addr, 16'h0500);
      chk("b16_hrvalid_last", bus.hsh_rvalid, 1);
      chk("b16_hrdata_last", bus.hsh_rdata, rom_f(16'h043C));
      chk("b16_busy_off", bus.hsh_busy, 0);
      step();
      chk("b16_crvalid", bus.cpu_rvalid, 1);
      chk("b16_crdata", bus.cpu_rdata, rom_f(16'h0500));
      step();

      // reset during an 8-beat burst
      hsh_burst_start(16'h0600, 4'd7);
      step();
      chk("mid_hrvalid_pre", bus.hsh_rvalid, 1);
      rst = 1'b1;
      #1;
      chk("mid_rom_addr", bus.rom_addr, 0);
      chk("mid_busy", bus.hsh_busy, 0);
      chk("mid_rvalid", {bus.cpu_rvalid, bus.hsh_rvalid}, 0);
      chk("mid_rdata", bus.hsh_rdata, 0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_rst_rvalid", {bus.cpu_rvalid, bus.hsh_rvalid}, 0);
         chk("post_rst_addr", bus.rom_addr, 0);
      end
      cpu_read(16'h0700);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule

// File: doc/oc8051_cxrom_arb.md
# oc8051_cxrom_arb

Two-port arbiter that shares the single fully-combinational code ROM between the oc8051 instruction-fetch port (CPU) and the secure-boot hash engine (HSH). It sits between both requesters and the ROM, registers the ROM address, returns registered read data with a per-port valid pulse, and supports fixed-length HSH bursts with auto-incrementing addresses. CPU has priority; a starvation guard bounds HSH wait.

## Interface

- AW, 16, ROM address width
- DW, 32, ROM data width
- MAX_WAIT, 4, cycles HSH may be refused before it wins priority (1..15)
- STEP, 4, address increment per burst beat (bytes per ROM word)

- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock; asynchronous and active-high
- cpu_req  in  1  CPU read request, held until granted
- cpu_addr  in  AW  CPU read address, stable while cpu_req
- cpu_gnt  out  1  request accepted at this edge (combinational)
- cpu_rdata  out  DW  registered read data
- cpu_rvalid  out  1  one-cycle pulse, cpu_rdata valid
- hsh_req  in  1  HSH read/burst request, held until granted
- hsh_addr  in  AW  burst start address
- hsh_len  in  4  burst length minus one (0 = 1 beat, 15 = 16 beats)
- hsh_gnt  out  1  burst accepted at this edge (combinational)
- hsh_rdata  out  DW  registered read data
- hsh_rvalid  out  1  one-cycle pulse per beat
- hsh_busy  out  1  burst in progress (registered)
- rom_addr  out  AW  address to ROM (registered)
- rom_data  in  DW  combinational ROM data for rom_addr

## Operation

- States: IDLE, SINGLE (CPU word or 1-beat HSH), BURST (beats remaining > 0).
- Grant window: state IDLE, SINGLE, or BURST with remain==0. Outside window both gnt = 0.
- Priority in window: if hsh_req and wait_cnt == MAX_WAIT -> HSH; else cpu_req -> CPU; else hsh_req -> HSH; else none. At most one gnt per cycle.
- wait_cnt: increments (saturating at MAX_WAIT) each cycle hsh_req=1 and hsh_gnt=0; clears on hsh_gnt.
- On CPU grant: addr_q <= cpu_addr, src_q <= CPU, next SINGLE.
- On HSH grant: addr_q <= hsh_addr, remain <= hsh_len, src_q <= HSH; next BURST if hsh_len>0 else SINGLE.
- In BURST with remain>0 and no new grant: addr_q <= addr_q + STEP (modulo 2^AW, 0xFFFC -> 0x0000), remain <= remain-1.
- No grant and remain==0: next IDLE; addr_q holds.
- rom_addr = addr_q. Each cycle in SINGLE/BURST, rom_data is captured into rdata_q and the source into vsrc_q; rvalid asserts on the matching port next cycle.
- Both rdata outputs are driven from rdata_q; only the matching rvalid pulses.
- hsh_busy = 1 from the cycle after hsh_gnt through the cycle presenting the final beat's address.

## Timing

- Reset values: cpu_gnt/hsh_gnt 0 (forced while rst), rdata 0, rvalid 0, rom_addr 0, hsh_busy 0, wait_cnt 0, state IDLE.
- Latency: gnt in cycle T -> rom_addr valid T+1 -> rvalid T+2. Throughput 1 word/cycle; back-to-back grants have no bubble.
- Burst of L beats granted at T: addresses in T+1..T+L, rvalid in T+2..T+L+1; next grant possible in T+L.
- CPU worst-case wait: 16 cycles (max burst). HSH worst-case wait: MAX_WAIT+1 grant windows.
- Simultaneous requests, wait_cnt < MAX_WAIT: CPU granted, wait_cnt increments.
- Reset asserted mid-burst: burst abandoned immediately, no rvalid pulses after reset release until a new grant.
- Requester deasserting req before gnt: legal, nothing issued.

## Structure

- Package oc8051_cxrom_pkg: state enum (IDLE/SINGLE/BURST), source enum (SRC_CPU/SRC_HSH), AW/DW defaults, STEP.
- One sub-module: oc8051_cxrom_prio — combinational starvation-guarded priority picker plus wait_cnt register.

## Test plan

- Reset, then cpu_req addr 0x0010 -> cpu_gnt at T, rom_addr 0x0010 at T+1, cpu_rvalid and cpu_rdata = ROM[0x0010] at T+2.
- hsh_req addr 0x0100 len 3 -> rom_addr 0x0100/0x0104/0x0108/0x010C, four hsh_rvalid pulses with matching data, hsh_busy for 4 cycles.
- cpu_req and hsh_req held together from reset, MAX_WAIT=4 -> four CPU grants, fifth grant to HSH, wait_cnt cleared.
- HSH burst at 0xFFF8 len 3 -> addresses 0xFFF8, 0xFFFC, 0x0000, 0x0004.
- cpu_req during 16-beat burst -> cpu_gnt only in final-address cycle, cpu_rvalid two cycles later, no bubble.
- rst asserted after beat 2 of 8 -> all outputs zero asynchronously, no further rvalid, new CPU read works normally.
